// File: rtl/tdc_sched_pkg.sv
// Shared widths and bundle types for the TDC conversion scheduler.
// Slots hold {int, frac}; the tag pipe carries {v, ch}.
package tdc_sched_pkg;

    localparam int INT_W  = 10;
    localparam int FRAC_W = 7;
    localparam int RES_W  = 37;
    localparam int CH_W   = 4;

    typedef struct packed {
        logic [INT_W-1:0]  ival;
        logic [FRAC_W-1:0] frac;
    } meas_t;

    typedef struct packed {
        logic            v;
        logic [CH_W-1:0] ch;
    } tag_t;

endpackage

// File: rtl/tdc_conv_sched_rr_arbiter.sv
// Round-robin arbiter with an internal rotating pointer.
// The search begins at the channel after the last grant.
module rr_arbiter #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] c;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
            c = (c == IW'(N - 1)) ? '0 : c + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/tdc_conv_sched.sv
// Shares one fixed-latency TDC converter among NCH capture channels,
// issuing one conversion per clock and tagging results by channel.
module tdc_conv_sched
    import tdc_sched_pkg::*;
#(
    parameter  int NCH = 8,
    parameter  int LAT = 6,
    localparam int CW  = $clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          ch_valid,
    input  logic [NCH*INT_W-1:0]    ch_int,
    input  logic [NCH*FRAC_W-1:0]   ch_frac,
    output logic                    mlt_start,
    output logic [INT_W-1:0]        mlt_int,
    output logic [FRAC_W-1:0]       mlt_frac,
    input  logic [RES_W-1:0]        mlt_result,
    input  logic                    mlt_dval,
    output logic                    res_valid,
    output logic [CW-1:0]           res_ch,
    output logic [RES_W-1:0]        res_data,
    output logic [15:0]             drop_cnt,
    output logic [NCH-1:0]          ovr_flag,
    output logic                    tag_err,
    input  logic                    clr
);

    meas_t          slot [NCH];
    logic [NCH-1:0] pend;
    logic [NCH-1:0] gnt;
    logic [NCH-1:0] drop;
    logic [CW-1:0]  gidx;
    logic [CW-1:0]  issue_ch;
    logic           any_req;
    tag_t           tags [LAT];
    tag_t           last;
    logic           hit;
    logic           mismatch;
    logic [4:0]     ndrop;
    logic [16:0]    drop_sum;

    assign any_req = |pend;

    rr_arbiter #(
        .N (NCH)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (pend),
        .adv (any_req),
        .gnt (gnt),
        .idx (gidx)
    );

    // A granted channel may reload in the same cycle without dropping.
    assign drop = ch_valid & pend & ~gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            pend <= ch_valid | (pend & ~gnt);
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i]) begin
                    slot[i].ival <= ch_int[i*INT_W +: INT_W];
                    slot[i].frac <= ch_frac[i*FRAC_W +: FRAC_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mlt_start <= 1'b0;
            mlt_int   <= '0;
            mlt_frac  <= '0;
            issue_ch  <= '0;
        end else begin
            mlt_start <= any_req;
            if (any_req) begin
                mlt_int  <= slot[gidx].ival;
                mlt_frac <= slot[gidx].frac;
                issue_ch <= gidx;
            end
        end
    end

    // Tag stage k lines up with the converter's stage k.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) begin
                tags[k] <= '0;
            end
        end else begin
            tags[0].v  <= mlt_start;
            tags[0].ch <= CH_W'(issue_ch);
            for (int k = 1; k < LAT; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign last     = tags[LAT-1];
    assign hit      = mlt_dval & last.v;
    assign mismatch = mlt_dval ^ last.v;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= hit;
            if (hit) begin
                res_ch   <= last.ch[CW-1:0];
                res_data <= mlt_result;
            end
        end
    end

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NCH; i++) begin
            ndrop = ndrop + 5'(drop[i]);
        end
        drop_sum = {1'b0, clr ? 16'h0 : drop_cnt} + 17'(ndrop);
    end

    // Clear wins over history but not over events of the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            ovr_flag <= '0;
            tag_err  <= 1'b0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ovr_flag <= (clr ? '0 : ovr_flag) | drop;
            tag_err  <= (clr ? 1'b0 : tag_err) | mismatch;
        end
    end

endmodule
